// File: rtl/mult_writeback.sv
//==============================================================================
// Module      : mult_writeback
// Description : Multiply tag pipeline, ALU/multiply write-port merge with an
//               in-order displaced-result buffer, back-pressure and optional
//               RAW hazard detection (enabled by MULT_WB_SCOREBOARD_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_writeback #(
  parameter int MULT_STAGES = 2,
  parameter int BUF_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        issue_valid,
  input  logic        issue_mult,
  input  logic [4:0]  issue_rd_idx,
  input  logic [4:0]  issue_ra_idx,
  input  logic [4:0]  issue_rb_idx,
  input  logic [31:0] mult_wb_value,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_rd_idx,
  input  logic [31:0] alu_wb_value,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic        hazard
);

  localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int c_OCC_W = $clog2(BUF_DEPTH + MULT_STAGES + 1);

  logic [MULT_STAGES-1:0] r_tag_v;
  logic [4:0]             r_tag_rd [MULT_STAGES];

  logic [4:0]             r_buf_rd   [BUF_DEPTH];
  logic [31:0]            r_buf_data [BUF_DEPTH];
  logic [c_PTR_W-1:0]     r_head;
  logic [c_PTR_W-1:0]     r_tail;
  logic [c_CNT_W-1:0]     r_count;

  logic [4:0]             w_last_rd;
  logic                   w_last_live;
  logic                   w_buf_empty;
  logic                   w_direct;
  logic                   w_push;
  logic                   w_pop;
  logic [c_OCC_W-1:0]     w_occ;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Last stage is consumed only when the pipeline advances; rd=0 is dropped.
  assign w_last_rd   = r_tag_rd[MULT_STAGES-1];
  assign w_last_live = r_tag_v[MULT_STAGES-1] & ~hold & (|w_last_rd);
  assign w_buf_empty = (r_count == '0);
  assign w_direct    = w_last_live & ~alu_wb_valid & w_buf_empty;
  assign w_push      = w_last_live & ~w_direct;
  assign w_pop       = ~alu_wb_valid & ~w_buf_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int i = 0; i < MULT_STAGES; i++) r_tag_rd[i] <= '0;
    end else if (!hold) begin
      r_tag_v[0]  <= issue_valid & issue_mult;
      r_tag_rd[0] <= issue_rd_idx;
      for (int i = MULT_STAGES - 1; i > 0; i--) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_rd[i] <= r_tag_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf_rd[r_tail]   <= w_last_rd;
        r_buf_data[r_tail] <= mult_wb_value;
        r_tail             <= f_ptr_inc(r_tail);
      end
      if (w_pop) r_head <= f_ptr_inc(r_head);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (alu_wb_valid) begin
        rf_we    = 1'b1;
        rf_waddr = alu_rd_idx;
        rf_wdata = alu_wb_value;
      end else if (w_pop) begin
        rf_we    = 1'b1;
        rf_waddr = r_buf_rd[r_head];
        rf_wdata = r_buf_data[r_head];
      end else if (w_direct) begin
        rf_we    = 1'b1;
        rf_waddr = w_last_rd;
        rf_wdata = mult_wb_value;
      end
    end
  end

  // Every in-flight tag already owns a future buffer slot.
  always_comb begin
    w_occ = c_OCC_W'(r_count);
    for (int i = 0; i < MULT_STAGES; i++) w_occ = w_occ + c_OCC_W'(r_tag_v[i]);
    stall_req = ~rst & (w_occ >= c_OCC_W'(BUF_DEPTH));
  end

`ifdef MULT_WB_SCOREBOARD_EN
  logic [BUF_DEPTH-1:0] r_buf_v;
  logic                 w_ra_hit;
  logic                 w_rb_hit;

  // Occupancy per slot; on a full-buffer pop+push the push reclaims the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_v <= '0;
    end else begin
      if (w_pop)  r_buf_v[r_head] <= 1'b0;
      if (w_push) r_buf_v[r_tail] <= 1'b1;
    end
  end

  always_comb begin
    w_ra_hit = 1'b0;
    w_rb_hit = 1'b0;
    for (int i = 0; i < MULT_STAGES; i++) begin
      if (r_tag_v[i] && (r_tag_rd[i] == issue_ra_idx)) w_ra_hit = 1'b1;
      if (r_tag_v[i] && (r_tag_rd[i] == issue_rb_idx)) w_rb_hit = 1'b1;
    end
    for (int j = 0; j < BUF_DEPTH; j++) begin
      if (r_buf_v[j] && (r_buf_rd[j] == issue_ra_idx)) w_ra_hit = 1'b1;
      if (r_buf_v[j] && (r_buf_rd[j] == issue_rb_idx)) w_rb_hit = 1'b1;
    end
    hazard = ~rst & issue_valid &
             ((w_ra_hit & (|issue_ra_idx)) | (w_rb_hit & (|issue_rb_idx)));
  end
`else
  logic w_unused_src;
  assign w_unused_src = ^{issue_ra_idx, issue_rb_idx};
  assign hazard       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_writeback.sv
//==============================================================================
// Module      : tb_mult_writeback
// Description : Randomized scoreboard bench for mult_writeback against an
//               in-order retirement model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mult_writeback;

  localparam int MS = 2;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_mult = 1'b0;
  logic [4:0]  issue_rd_idx = '0;
  logic [4:0]  issue_ra_idx = '0;
  logic [4:0]  issue_rb_idx = '0;
  logic [31:0] mult_wb_value = '0;
  logic        alu_wb_valid = 1'b0;
  logic [4:0]  alu_rd_idx = '0;
  logic [31:0] alu_wb_value = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic        hazard;

  mult_writeback #(.MULT_STAGES(MS), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .issue_valid(issue_valid), .issue_mult(issue_mult),
    .issue_rd_idx(issue_rd_idx), .issue_ra_idx(issue_ra_idx), .issue_rb_idx(issue_rb_idx),
    .mult_wb_value(mult_wb_value),
    .alu_wb_valid(alu_wb_valid), .alu_rd_idx(alu_rd_idx), .alu_wb_value(alu_wb_value),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .hazard(hazard)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; int iadv; } flight_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } pend_t;
  typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } exp_t;

  flight_t infl[$];   // issued multiplies not yet retired from the pipe
  pend_t   pend[$];   // results waiting for the write port, oldest first
  exp_t    exp_q[$];  // expected register-file writes

  int   adv = 0;      // number of cycles the pipeline has advanced
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic exp_stall = 1'b0;
  logic exp_haz = 1'b0;

  function automatic logic in_flight(input logic [4:0] r);
    logic hit = 1'b0;
    if (r == 5'd0) return 1'b0;
    foreach (infl[i]) if (infl[i].rd == r) hit = 1'b1;
    foreach (pend[i]) if (pend[i].rd == r) hit = 1'b1;
    return hit;
  endfunction

  task automatic drive_cycle(input bit do_rst, input int alu_pct, input int hold_pct,
                             input int iss_pct);
    logic    model_stall;
    flight_t f;
    pend_t   p;
    @(posedge clk);
    cyc++;
    #1;
    model_stall  = (infl.size() + pend.size()) >= BD;
    rst          = do_rst;
    hold         = ($urandom_range(0, 99) < hold_pct);
    alu_wb_valid = ($urandom_range(0, 99) < alu_pct);
    alu_rd_idx   = 5'($urandom_range(0, 31));
    alu_wb_value = $urandom;
    issue_valid  = ($urandom_range(0, 99) < iss_pct);
    issue_mult   = ($urandom_range(0, 99) < 70);
    if (issue_valid && issue_mult && model_stall) issue_mult = 1'b0;
    issue_rd_idx = 5'($urandom_range(0, 7));
    issue_ra_idx = 5'($urandom_range(0, 7));
    issue_rb_idx = 5'($urandom_range(0, 7));
    if (infl.size() > 0 && (adv - infl[0].iadv) == MS) mult_wb_value = infl[0].data;
    else mult_wb_value = $urandom;

    if (do_rst) begin
      exp_stall = 1'b0;
      exp_haz   = 1'b0;
      infl.delete();
      pend.delete();
    end else begin
      exp_stall = model_stall;
`ifdef MULT_WB_SCOREBOARD_EN
      exp_haz = issue_valid & (in_flight(issue_ra_idx) | in_flight(issue_rb_idx));
`else
      exp_haz = 1'b0;
`endif
      if (!hold && infl.size() > 0 && (adv - infl[0].iadv) == MS) begin
        f = infl.pop_front();
        if (f.rd != 5'd0) pend.push_back('{rd: f.rd, data: f.data});
      end
      if (alu_wb_valid) begin
        exp_q.push_back('{cyc: cyc, addr: alu_rd_idx, data: alu_wb_value});
      end else if (pend.size() > 0) begin
        p = pend.pop_front();
        exp_q.push_back('{cyc: cyc, addr: p.rd, data: p.data});
      end
      if (!hold) begin
        if (issue_valid && issue_mult)
          infl.push_back('{rd: issue_rd_idx, data: $urandom, iadv: adv});
        adv++;
      end
    end
  endtask

  // Monitor: compares every presented write and the per-cycle status outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_we) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write: unexpected write cyc=%0d addr=%0d data=%h, none required",
                   cyc, rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.addr != rf_waddr || e.data != rf_wdata) begin
            bad++;
            $display("FAIL write: got cyc=%0d addr=%0d data=%h, want cyc=%0d addr=%0d data=%h",
                     cyc, rf_waddr, rf_wdata, e.cyc, e.addr, e.data);
          end
        end
      end else begin
        total++;
        if (rf_waddr != 5'd0 || rf_wdata != 32'd0) begin
          bad++;
          $display("FAIL idle_port: cyc=%0d got addr=%0d data=%h, want 0/0",
                   cyc, rf_waddr, rf_wdata);
        end
      end
      total++;
      if (stall_req !== exp_stall) begin
        bad++;
        $display("FAIL stall: cyc=%0d got %b want %b", cyc, stall_req, exp_stall);
      end
      total++;
      if (hazard !== exp_haz) begin
        bad++;
        $display("FAIL hazard: cyc=%0d got %b want %b", cyc, hazard, exp_haz);
      end
      total++;
      if (issue_valid && issue_mult && stall_req) begin
        bad++;
        $display("FAIL protocol: cyc=%0d multiply issued while stall_req=%b, want no issue",
                 cyc, stall_req);
      end
    end
  end

  initial begin
    int alu_tab  [4] = '{0, 35, 75, 95};
    int hold_tab [4] = '{0, 10, 30, 5};
    int iss_tab  [4] = '{50, 80, 90, 60};
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 0, 0, 0);
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 700; n++)
        drive_cycle(($urandom_range(0, 149) == 0), alu_tab[ph], hold_tab[ph], iss_tab[ph]);
    end
    for (int n = 0; n < 4 * (MS + BD) + 4; n++) drive_cycle(1'b0, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d required writes never appeared, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
